// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU result path.
//   sat_mode_e   - per-beat saturation mode carried with each result
//   fpu_flags_t  - {overflow, underflow, inexact} exception flags
//   buf_state_e  - occupancy states of the result-stage skid buffer
//   fp_max_finite / fp_inf - bit patterns (sign clear) of the largest finite
//                  value and of +infinity for a given EXP_W/MAN_W. They
//                  return 64 bits so any format up to 64 bits wide fits;
//                  callers keep the low W bits.
package fpu_pkg;

    typedef enum logic [1:0] {
        SAT_LEGACY = 2'd0,
        SAT_MAXF   = 2'd1,
        SAT_INF    = 2'd2,
        SAT_PASS   = 2'd3
    } sat_mode_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // Exponent all-ones minus one, mantissa all-ones.
    function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
        logic [63:0] e_field;
        logic [63:0] m_field;
        e_field = ((64'd1 << exp_w) - 64'd2) << man_w;
        m_field = (64'd1 << man_w) - 64'd1;
        return e_field | m_field;
    endfunction

    // Exponent all-ones, mantissa zero.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

endpackage

// File: rtl/fpu_saturate.sv
// fpu_saturate: combinational substitution of a rounded result according to
// its exception flags and the beat's saturation mode.
//   result     in  W  rounded {sign, exp, man}
//   flags      in  3  {overflow, underflow, inexact}
//   mode       in  2  sat_mode_e
//   sat_result out W  result after substitution
// Underflow wins over overflow; inexact never triggers a substitution.
module fpu_saturate
    import fpu_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] result,
    input  fpu_flags_t   flags,
    input  sat_mode_e    mode,
    output logic [W-1:0] sat_result
);

    localparam logic [63:0]  MAXF64 = fp_max_finite(EXP_W, MAN_W);
    localparam logic [63:0]  INF64  = fp_inf(EXP_W, MAN_W);
    localparam logic [W-1:0] MAXF   = MAXF64[W-1:0];
    localparam logic [W-1:0] INF    = INF64[W-1:0];

    logic [W-1:0] sign_mask;

    assign sign_mask = {result[W-1], {(W-1){1'b0}}};

    always_comb begin
        sat_result = result;
        if (mode != SAT_PASS) begin
            if (flags.underflow) begin
                // Legacy mode flushes to +0 regardless of sign.
                sat_result = (mode == SAT_LEGACY) ? '0 : sign_mask;
            end else if (flags.overflow) begin
                case (mode)
                    SAT_LEGACY: sat_result = MAXF;
                    SAT_MAXF:   sat_result = MAXF | sign_mask;
                    SAT_INF:    sat_result = INF | sign_mask;
                    default:    sat_result = result;
                endcase
            end
        end
    end

endmodule

// File: rtl/fpu_result_stage.sv
// fpu_result_stage: registered, handshaked output stage of the FPU datapath.
// Each accepted beat is saturated on the way in and stored with its flags in
// a 2-entry skid buffer (main register drives out_*, skid holds the overflow
// beat while downstream stalls). in_ready and out_valid are registered.
//   clk, rstn                     clock, async active-low reset
//   in_valid/in_ready             upstream handshake
//   in_result, in_overflow,
//   in_underflow, in_inexact,
//   in_sat_mode                   beat payload
//   out_valid/out_ready           downstream handshake
//   out_result, out_overflow,
//   out_underflow, out_inexact    retiring beat
//   flags_clr, fflags             sticky flag clear / sticky {ov, un, ix};
//                                 present only with FPU_STICKY_FLAGS_EN
module fpu_result_stage
    import fpu_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_result,
    input  logic         in_overflow,
    input  logic         in_underflow,
    input  logic         in_inexact,
    input  logic [1:0]   in_sat_mode,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef FPU_STICKY_FLAGS_EN
    input  logic         flags_clr,
    output logic [2:0]   fflags,
`endif
    output logic [W-1:0] out_result,
    output logic         out_overflow,
    output logic         out_underflow,
    output logic         out_inexact
);

    typedef struct packed {
        logic [W-1:0] result;
        fpu_flags_t   flags;
    } entry_t;

    buf_state_e   state;
    entry_t       main_q;
    entry_t       skid_q;
    entry_t       in_entry;
    fpu_flags_t   in_flags;
    logic [W-1:0] sat_result;
    logic         accept;
    logic         retire;

    assign in_flags = '{overflow: in_overflow, underflow: in_underflow, inexact: in_inexact};

    fpu_saturate #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_sat (
        .result     (in_result),
        .flags      (in_flags),
        .mode       (sat_mode_e'(in_sat_mode)),
        .sat_result (sat_result)
    );

    assign in_entry = '{result: sat_result, flags: in_flags};
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= BUF_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q    <= in_entry;
                        out_valid <= 1'b1;
                        state     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && retire) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_q   <= in_entry;
                        in_ready <= 1'b0;
                        state    <= BUF_TWO;
                    end else if (retire) begin
                        out_valid <= 1'b0;
                        state     <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (retire) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                default: begin
                    state     <= BUF_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_result    = main_q.result;
    assign out_overflow  = main_q.flags.overflow;
    assign out_underflow = main_q.flags.underflow;
    assign out_inexact   = main_q.flags.inexact;

`ifdef FPU_STICKY_FLAGS_EN
    // A clear in the same cycle as a retire keeps only the retiring flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fflags <= '0;
        end else if (flags_clr || retire) begin
            fflags <= (flags_clr ? 3'b000 : fflags) | (retire ? main_q.flags : 3'b000);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
module tb_fpu_result_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow, in_underflow, in_inexact;
    logic [1:0]  in_sat_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact;
`ifdef FPU_STICKY_FLAGS_EN
    logic        flags_clr;
    logic [2:0]  fflags;
`endif

    fpu_result_stage dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_overflow   (in_overflow),
        .in_underflow  (in_underflow),
        .in_inexact    (in_inexact),
        .in_sat_mode   (in_sat_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef FPU_STICKY_FLAGS_EN
        .flags_clr     (flags_clr),
        .fflags        (fflags),
`endif
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ov, un, ix;
    } beat_t;

    beat_t       q[$];
    logic [2:0]  mf;          // sticky flag model
    bit          prev_stall;
    logic [31:0] prev_res;
    int          retired;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference saturation from the mode rules, default 8/23 format.
    function automatic logic [31:0] ref_sat(input logic [1:0] m, input logic ov, input logic un,
                                            input logic [31:0] r);
        logic s;
        s = r[31];
        if (m == 2'd3 || (!ov && !un)) return r;
        if (un) return (m == 2'd0) ? 32'h0 : {s, 31'h0};
        case (m)
            2'd0:    return 32'h7F7FFFFF;
            2'd1:    return {s, 31'h7F7FFFFF};
            default: return {s, 31'h7F800000};
        endcase
    endfunction

    // One clock cycle, entered and left at a negedge with inputs already driven.
    task automatic step(output bit acc);
        bit ret;
        beat_t b;
        if (prev_stall) chk("hold_result", out_result, prev_res);
        chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
`ifdef FPU_STICKY_FLAGS_EN
        chk("fflags", {29'b0, fflags}, {29'b0, mf});
`endif
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        if (ret) begin
            if (q.size() == 0) begin
                chk("spurious_retire", 32'd1, 32'd0);
            end else begin
                chk("out_result", out_result, q[0].res);
                chk("out_flags", {29'b0, out_overflow, out_underflow, out_inexact},
                    {29'b0, q[0].ov, q[0].un, q[0].ix});
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        @(posedge clk);
        b = '0;
        if (ret && q.size() > 0) begin
            b = q.pop_front();
            retired++;
        end
`ifdef FPU_STICKY_FLAGS_EN
        if (flags_clr || ret) mf = (flags_clr ? 3'b000 : mf) | (ret ? {b.ov, b.un, b.ix} : 3'b000);
`endif
        if (acc) q.push_back('{res: ref_sat(in_sat_mode, in_overflow, in_underflow, in_result),
                               ov: in_overflow, un: in_underflow, ix: in_inexact});
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] m, input logic ov, input logic un, input logic ix,
                         input logic [31:0] r);
        in_valid     = 1'b1;
        in_sat_mode  = m;
        in_overflow  = ov;
        in_underflow = un;
        in_inexact   = ix;
        in_result    = r;
    endtask

    typedef struct packed {
        logic [1:0]  mode;
        logic        ov, un, ix;
        logic [31:0] res;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        if ($time > 0) ;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int idx;
        logic [31:0] abc[3];

        tbl[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000};
        tbl[1]  = '{2'd3, 1'b0, 1'b0, 1'b0, 32'h40000000, 32'h40000000};
        tbl[2]  = '{2'd0, 1'b1, 1'b0, 1'b1, 32'hC2000000, 32'h7F7FFFFF};
        tbl[3]  = '{2'd0, 1'b0, 1'b1, 1'b1, 32'hC2000000, 32'h00000000};
        tbl[4]  = '{2'd1, 1'b1, 1'b0, 1'b0, 32'hC2000000, 32'hFF7FFFFF};
        tbl[5]  = '{2'd2, 1'b1, 1'b0, 1'b0, 32'hC2000000, 32'hFF800000};
        tbl[6]  = '{2'd2, 1'b1, 1'b1, 1'b0, 32'hC2000000, 32'h80000000};
        tbl[7]  = '{2'd1, 1'b0, 1'b1, 1'b0, 32'hC2000000, 32'h80000000};
        tbl[8]  = '{2'd3, 1'b1, 1'b1, 1'b1, 32'hC2000000, 32'hC2000000};
        tbl[9]  = '{2'd0, 1'b0, 1'b0, 1'b1, 32'hC2000000, 32'hC2000000};
        tbl[10] = '{2'd2, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h00000000};
        tbl[11] = '{2'd1, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h7F7FFFFF};

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_overflow = 1'b0; in_underflow = 1'b0; in_inexact = 1'b0;
        in_sat_mode = 2'd0; mf = '0; prev_stall = 1'b0; prev_res = '0; retired = 0;
`ifdef FPU_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
`ifdef FPU_STICKY_FLAGS_EN
        chk("rst_fflags", {29'b0, fflags}, 32'd0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        // Table: streaming with out_ready=1, each beat visible one cycle after accept.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].mode, tbl[i].ov, tbl[i].un, tbl[i].ix, tbl[i].res);
            step(acc);
            chk($sformatf("tbl%0d_acc", i), {31'b0, acc}, 32'd1);
            chk($sformatf("tbl%0d_result", i), out_result, tbl[i].exp);
            chk($sformatf("tbl%0d_flags", i), {29'b0, out_overflow, out_underflow, out_inexact},
                {29'b0, tbl[i].ov, tbl[i].un, tbl[i].ix});
        end
        in_valid = 1'b0;
        step(acc);

        // Backpressure: A and B held, C stalled, then drained in order.
        abc[0] = 32'h11111111; abc[1] = 32'h22222222; abc[2] = 32'h33333333;
        idx = 0; retired = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(2'd3, 1'b0, 1'b0, 1'b0, abc[idx]);
            step(acc);
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 32'd2);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_head", out_result, abc[0]);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (idx < 3 || q.size() > 0); c++) begin
            if (idx < 3) drive(2'd3, 1'b0, 1'b0, 1'b0, abc[idx]);
            else in_valid = 1'b0;
            step(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_retired", retired, 32'd3);

        // Reset while full: outputs clear asynchronously, nothing stale afterwards.
        out_ready = 1'b0;
        drive(2'd3, 1'b0, 1'b0, 1'b0, 32'hAAAA0001); step(acc);
        drive(2'd3, 1'b0, 1'b0, 1'b0, 32'hAAAA0002); step(acc);
        in_valid = 1'b0;
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_out_result", out_result, 32'd0);
        q.delete(); mf = '0; prev_stall = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step(acc);

`ifdef FPU_STICKY_FLAGS_EN
        drive(2'd3, 1'b0, 1'b0, 1'b1, 32'h3F800001); step(acc);
        drive(2'd3, 1'b1, 1'b0, 1'b0, 32'h3F800002); step(acc);
        in_valid = 1'b0; step(acc); step(acc);
        chk("sticky_101", {29'b0, fflags}, 32'd5);
        drive(2'd3, 1'b0, 1'b1, 1'b0, 32'h00000001); step(acc);
        in_valid = 1'b0; flags_clr = 1'b1; step(acc);
        flags_clr = 1'b0; step(acc);
        chk("sticky_clr_010", {29'b0, fflags}, 32'd2);
        flags_clr = 1'b1; step(acc);
        flags_clr = 1'b0; step(acc);
        chk("sticky_clr_only", {29'b0, fflags}, 32'd0);
`endif

        // Randomised traffic against the queue model.
        for (int c = 0; c < 1500; c++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 9) < 6);
            in_sat_mode  = 2'($urandom_range(0, 3));
            in_overflow  = ($urandom_range(0, 3) == 0);
            in_underflow = ($urandom_range(0, 3) == 0);
            in_inexact   = ($urandom_range(0, 1) == 0);
            in_result    = $urandom;
`ifdef FPU_STICKY_FLAGS_EN
            flags_clr    = ($urandom_range(0, 9) == 0);
`endif
            step(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
`ifdef FPU_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        for (int c = 0; c < 4; c++) step(acc);
        chk("drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
